// File: rtl/rom_select_buttons_pkg.sv
// Shared definitions for the ROM-select button conditioner: width helpers,
// button level encoding, index field layout and the selection tracker states.
package rom_select_buttons_pkg;

    // Ceiling log2 for elaboration-time width derivation; clog2(1) = 0.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned w = 0; w < 32; w++) begin
            if ((64'd1 << w) < 64'(value)) begin
                result = w + 1;
            end
        end
        return result;
    endfunction

    // Width of the button-number field inside the ROM index.
    function automatic int unsigned num_width(input int unsigned num_btn);
        return clog2(num_btn);
    endfunction

    // Full ROM index width: button-number field plus the shift bit above it.
    function automatic int unsigned idx_width(input int unsigned num_btn);
        return clog2(num_btn) + 1;
    endfunction

    // Bit position of the shift flag inside the ROM index.
    function automatic int unsigned shift_pos(input int unsigned num_btn);
        return clog2(num_btn);
    endfunction

    localparam int unsigned NUM_LSB = 0;

    typedef enum logic {
        RELEASED = 1'b0,
        PRESSED  = 1'b1
    } level_e;

    typedef enum logic {
        SEL_IDLE  = 1'b0,
        SEL_TRACK = 1'b1
    } sel_state_e;

endpackage

// File: rtl/rom_select_buttons_if.sv
// Front-panel bundle: raw button pins towards the conditioner, ROM index,
// reload pulse and held flag back towards the memory loader.
interface rom_select_buttons_if
    import rom_select_buttons_pkg::*;
#(
    parameter int unsigned NUM_BTN = 4,
    parameter int unsigned IDX_W   = idx_width(NUM_BTN)
);
    logic [NUM_BTN:0]   btn_raw;
    logic [IDX_W-1:0]   index;
    logic               reload;
    logic               held;

    modport master (
        output btn_raw,
        input  index,
        input  reload,
        input  held
    );

    modport slave (
        input  btn_raw,
        output index,
        output reload,
        output held
    );
endinterface

// File: rtl/rom_select_buttons_btn_debounce.sv
// One button pin: 2-flop synchroniser, polarity normalisation (pressed = 1)
// and, when BTN_DEBOUNCE_EN is defined, a stable-level debounce counter.
module btn_debounce
    import rom_select_buttons_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 65536,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic pin,
    output logic level
);
    // Pin value corresponding to a released button.
    localparam logic PIN_IDLE = ACTIVE_LOW ? 1'b1 : 1'b0;

    logic [1:0] sync_q;
    logic       sync_level;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q <= {2{PIN_IDLE}};
        end else begin
            sync_q <= {sync_q[0], pin};
        end
    end

    assign sync_level = ACTIVE_LOW ? ~sync_q[1] : sync_q[1];

`ifdef BTN_DEBOUNCE_EN
    localparam int unsigned            CNT_W    = clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]       CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             accepted_q;
    logic [CNT_W-1:0] count_q;

    // The >= compare keeps the counter from ever wrapping.
    always_ff @(posedge clock) begin
        if (reset) begin
            accepted_q <= RELEASED;
            count_q    <= '0;
        end else if (sync_level == accepted_q) begin
            count_q    <= '0;
        end else if (count_q >= CNT_LAST) begin
            accepted_q <= sync_level;
            count_q    <= '0;
        end else begin
            count_q    <= count_q + CNT_W'(1);
        end
    end

    assign level = accepted_q;
`else
    assign level = sync_level;
`endif

endmodule

// File: rtl/rom_select_buttons.sv
// ROM-select button conditioner: debounces NUM_BTN selects plus shift and
// emits a reload pulse with a stable index on full release (BTN_DEBOUNCE_EN).
module rom_select_buttons
    import rom_select_buttons_pkg::*;
#(
    parameter int unsigned NUM_BTN         = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 65536,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic                 clock,
    input  logic                 reset,
    rom_select_buttons_if.slave  btn
);
    localparam int unsigned IDX_W = idx_width(NUM_BTN);
    localparam int unsigned NUM_W = num_width(NUM_BTN);
    localparam int unsigned SEL_W = (NUM_W == 0) ? 1 : NUM_W;

    logic [NUM_BTN:0]   level;
    logic [NUM_BTN-1:0] sel_level;
    logic               shift_level;
    logic               held_now;
    logic [SEL_W-1:0]   lowest;
    logic [IDX_W-1:0]   pending_d;
    logic [IDX_W-1:0]   pending_q;
    logic [IDX_W-1:0]   index_q;
    logic               reload_d;
    logic               reload_q;
    sel_state_e         state_q;
    sel_state_e         state_d;

    for (genvar i = 0; i <= NUM_BTN; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .ACTIVE_LOW      (ACTIVE_LOW)
        ) u_btn (
            .clock (clock),
            .reset (reset),
            .pin   (btn.btn_raw[i]),
            .level (level[i])
        );
    end

    assign sel_level   = level[NUM_BTN-1:0];
    assign shift_level = level[NUM_BTN];
    assign held_now    = |sel_level;

    // Lowest-numbered pressed select wins on simultaneous presses.
    always_comb begin
        logic found;
        found  = 1'b0;
        lowest = '0;
        for (int unsigned i = 0; i < NUM_BTN; i++) begin
            if (sel_level[i] && !found) begin
                lowest = SEL_W'(i);
                found  = 1'b1;
            end
        end
    end

    if (NUM_W == 0) begin : g_shift_only
        assign pending_d = shift_level;
    end else begin : g_shift_num
        assign pending_d = {shift_level, lowest};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= SEL_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // SEL_TRACK means a select was held on the previous cycle, so leaving it
    // with nothing held is exactly the falling edge of held.
    always_comb begin
        state_d  = state_q;
        reload_d = 1'b0;
        case (state_q)
            SEL_IDLE: begin
                if (held_now) begin
                    state_d = SEL_TRACK;
                end
            end
            SEL_TRACK: begin
                if (!held_now) begin
                    state_d  = SEL_IDLE;
                    reload_d = 1'b1;
                end
            end
            default: begin
                state_d = SEL_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pending_q <= '0;
            index_q   <= '0;
            reload_q  <= 1'b0;
        end else begin
            reload_q <= reload_d;
            if (held_now) begin
                pending_q <= pending_d;
            end
            if (reload_d) begin
                index_q <= pending_q;
            end
        end
    end

    assign btn.index  = index_q;
    assign btn.reload = reload_q;
    assign btn.held   = held_now;

endmodule

// File: tb/tb_rom_select_buttons.sv
// Scoreboard bench for rom_select_buttons; expected reload timing adapts to
// whether BTN_DEBOUNCE_EN is defined for the build.
module tb_rom_select_buttons;
    localparam int unsigned NUM_BTN    = 4;
    localparam int unsigned DEB_CYCLES = 4;
`ifdef BTN_DEBOUNCE_EN
    localparam int unsigned DEB = DEB_CYCLES;
`else
    localparam int unsigned DEB = 0;
`endif
    localparam int unsigned LAT      = 3 + DEB;
    localparam int unsigned HELD_LAT = 2 + DEB;

    typedef struct {
        int unsigned at;
        logic [2:0]  idx;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    int unsigned cyc   = 0;
    int          checks = 0;
    int          fails  = 0;
    exp_t        sb[$];
    logic [2:0]  exp_index = '0;
    logic        prev_reload = 1'b0;
    bit          check_held_low = 1'b0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    rom_select_buttons_if #(.NUM_BTN(NUM_BTN), .IDX_W(3)) bus ();

    rom_select_buttons #(
        .NUM_BTN         (NUM_BTN),
        .DEBOUNCE_CYCLES (DEB_CYCLES),
        .ACTIVE_LOW      (1'b1)
    ) dut (
        .clock (clock),
        .reset (reset),
        .btn   (bus)
    );

    task automatic expect_eq(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0h, required %0h", name, cyc, act, req);
        end
    endtask

    // Monitor: pops an expectation on each reload pulse and tracks index hold.
    always @(negedge clock) begin
        if (reset) begin
            exp_index   = '0;
            prev_reload = 1'b0;
        end else begin
            if (bus.reload) begin
                if (prev_reload) begin
                    expect_eq("reload_width", 32'(prev_reload), 32'd0);
                end else if (sb.size() == 0) begin
                    expect_eq("spurious_reload", 32'(bus.reload), 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    expect_eq("reload_cycle", cyc, e.at);
                    exp_index = e.idx;
                end
            end
            expect_eq("index", 32'(bus.index), 32'(exp_index));
            if (check_held_low) begin
                expect_eq("held_glitch", 32'(bus.held), 32'd0);
            end
            prev_reload = bus.reload;
        end
    end

    task automatic step(input int unsigned n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic wait_neg(input int unsigned c);
        do @(negedge clock); while (cyc < c);
    endtask

    task automatic push(input logic [2:0] idx);
        exp_t e;
        e.at  = cyc + LAT;
        e.idx = idx;
        sb.push_back(e);
    endtask

    initial begin
        int unsigned k;
        bus.btn_raw = '1;
        reset = 1'b1;
        step(3);
        @(negedge clock);
        expect_eq("reset_index", 32'(bus.index), 32'd0);
        expect_eq("reset_reload", 32'(bus.reload), 32'd0);
        expect_eq("reset_held", 32'(bus.held), 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        step(2);

        // Basic select on button 2
        k = cyc;
        bus.btn_raw[2] = 1'b0;
        wait_neg(k + HELD_LAT - 1);
        expect_eq("held_before", 32'(bus.held), 32'd0);
        wait_neg(k + HELD_LAT);
        expect_eq("held_rise", 32'(bus.held), 32'd1);
        @(posedge clock);
        #1;
        while (cyc < k + 20) step(1);
        bus.btn_raw[2] = 1'b1;
        push(3'b010);
        step(15);

        // Shift held around button 1
        bus.btn_raw[4] = 1'b0;
        step(10);
        bus.btn_raw[1] = 1'b0;
        step(10);
        bus.btn_raw[1] = 1'b1;
        push(3'b101);
        step(10);
        bus.btn_raw[4] = 1'b1;
        step(15);

        // Reset while button 1 is held
        bus.btn_raw[1] = 1'b0;
        step(10);
        reset = 1'b1;
        step(1);
        @(negedge clock);
        expect_eq("midreset_index", 32'(bus.index), 32'd0);
        expect_eq("midreset_reload", 32'(bus.reload), 32'd0);
        expect_eq("midreset_held", 32'(bus.held), 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        bus.btn_raw[1] = 1'b1;
        step(20);

        // Simultaneous presses: lowest number wins
        bus.btn_raw[3] = 1'b0;
        bus.btn_raw[0] = 1'b0;
        step(10);
        bus.btn_raw[3] = 1'b1;
        bus.btn_raw[0] = 1'b1;
        push(3'b000);
        step(15);

        // Short pulses on button 2
`ifdef BTN_DEBOUNCE_EN
        check_held_low = 1'b1;
`endif
        repeat (10) begin
            bus.btn_raw[2] = 1'b0;
            step(3);
            bus.btn_raw[2] = 1'b1;
`ifndef BTN_DEBOUNCE_EN
            push(3'b010);
`endif
            step(3);
        end
        step(10);
        check_held_low = 1'b0;

        // One-cycle press of button 3
        bus.btn_raw[3] = 1'b0;
        step(1);
        bus.btn_raw[3] = 1'b1;
`ifndef BTN_DEBOUNCE_EN
        push(3'b011);
`endif
        step(15);

        for (int unsigned i = 0; i < 50 && sb.size() > 0; i++) step(1);
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            fails++;
            $display("FAIL missing_reload: got none, required pulse at cycle %0d index %0h", e.at, e.idx);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
